// File: rtl/ro_puf_controller.sv
// ro_puf_controller
//   Sequences a ring-oscillator PUF measurement. For each of N_BITS RO pairs it
//   steers the two RO muxes, clears both counters, gates them for a fixed window,
//   lets the last RO edges settle, then compares the counts into one response bit.
//   After the last bit the word is presented with a one-cycle resp_valid pulse.
//
//   Optional feature (macro RO_PUF_MARGIN_EN): adds the `unstable` output, which
//   flags bits whose count difference is below MARGIN or whose pair selects the
//   same oscillator. Without the macro the port and the subtractor are absent.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   start                    measurement request, accepted only in IDLE
//   challenge_a/_b           base mux selects, latched on start accept
//   busy                     high from the cycle after accept until DONE exits
//   resp_valid               one-cycle pulse, response is valid
//   response                 response word, held until the next accepted start
//   sel_a/_b                 RO mux selects
//   ro_en, cnt_clr           counter gate / clear to both RO counters
//   cnt_a/_b                 RO counter values (quasi-static when sampled)
//   unstable                 per-bit low-margin flag (RO_PUF_MARGIN_EN only)
module ro_puf_controller #(
    parameter int N_BITS        = 32,
    parameter int SEL_W         = 4,
    parameter int CNT_W         = 32,
    parameter int WINDOW        = 1000,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int MARGIN        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  challenge_a,
    input  logic [SEL_W-1:0]  challenge_b,
    output logic              busy,
    output logic              resp_valid,
    output logic [N_BITS-1:0] response,
    output logic [SEL_W-1:0]  sel_a,
    output logic [SEL_W-1:0]  sel_b,
    output logic              ro_en,
    output logic              cnt_clr,
`ifdef RO_PUF_MARGIN_EN
    output logic [N_BITS-1:0] unstable,
`endif
    input  logic [CNT_W-1:0]  cnt_a,
    input  logic [CNT_W-1:0]  cnt_b
);

    localparam int IW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    // One shared phase timer sized for the longest timed phase.
    localparam int TMAX = (WINDOW > CLR_CYCLES)
                          ? ((WINDOW > SETTLE_CYCLES) ? WINDOW : SETTLE_CYCLES)
                          : ((CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] CLR_LAST    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] WIN_LAST    = TW'(WINDOW - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, SELECT, CLEAR, COUNT, SETTLE, COMPARE, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    tmr;
    logic [IW-1:0]    idx;
    logic [SEL_W-1:0] ch_a_q, ch_b_q;
    logic             cmp_bit;

    // A pair that selects the same oscillator carries no entropy: force 0.
    assign cmp_bit = (sel_a != sel_b) && (cnt_a > cnt_b);

`ifdef RO_PUF_MARGIN_EN
    localparam logic [CNT_W:0] MARGIN_V = (CNT_W + 1)'(MARGIN);
    logic [CNT_W:0] diff, mag;
    logic           low_margin;
    always_comb begin
        diff       = {1'b0, cnt_a} - {1'b0, cnt_b};
        mag        = diff[CNT_W] ? (~diff + 1'b1) : diff;
        low_margin = (sel_a == sel_b) || (mag < MARGIN_V);
    end
`endif

    // Next state and Moore outputs; ro_en/cnt_clr decode from disjoint states
    // so they can never be high together.
    always_comb begin
        state_nxt = state;
        ro_en     = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = SELECT;
            SELECT:  state_nxt = CLEAR;
            CLEAR: begin
                cnt_clr = 1'b1;
                if (tmr == CLR_LAST) state_nxt = COUNT;
            end
            COUNT: begin
                ro_en = 1'b1;
                if (tmr == WIN_LAST) state_nxt = SETTLE;
            end
            SETTLE:  if (tmr == SETTLE_LAST) state_nxt = COMPARE;
            COMPARE: state_nxt = (idx == LAST_IDX) ? DONE : SELECT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmr        <= '0;
            idx        <= '0;
            ch_a_q     <= '0;
            ch_b_q     <= '0;
            sel_a      <= '0;
            sel_b      <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
`ifdef RO_PUF_MARGIN_EN
            unstable   <= '0;
`endif
        end else begin
            state      <= state_nxt;
            // Timer restarts on every state change, counts cycles within a phase.
            tmr        <= (state_nxt != state) ? '0 : tmr + 1'b1;
            // Registered on DONE exit, together with busy dropping.
            resp_valid <= (state == DONE);
            case (state)
                IDLE: if (start) begin
                    ch_a_q   <= challenge_a;
                    ch_b_q   <= challenge_b;
                    idx      <= '0;
                    response <= '0;
                    busy     <= 1'b1;
`ifdef RO_PUF_MARGIN_EN
                    unstable <= '0;
`endif
                end
                // Modular add: selects wrap around the oscillator array.
                SELECT: begin
                    sel_a <= ch_a_q + SEL_W'(idx);
                    sel_b <= ch_b_q + SEL_W'(idx);
                end
                COMPARE: begin
                    response[idx] <= cmp_bit;
`ifdef RO_PUF_MARGIN_EN
                    unstable[idx] <= low_margin;
`endif
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_controller.sv
module tb_ro_puf_controller;

    localparam int N_BITS = 4, SEL_W = 4, CNT_W = 16;
    localparam int WINDOW = 10, CLR_CYCLES = 2, SETTLE_CYCLES = 2, MARGIN = 8;
    localparam int LAT = N_BITS * (2 + CLR_CYCLES + WINDOW + SETTLE_CYCLES) + 1;

    logic              clk = 1'b0;
    logic              rst_n, start;
    logic [SEL_W-1:0]  challenge_a, challenge_b;
    logic              busy, resp_valid, ro_en, cnt_clr;
    logic [N_BITS-1:0] response;
    logic [SEL_W-1:0]  sel_a, sel_b;
    logic [CNT_W-1:0]  cnt_a = '0, cnt_b = '0;
`ifdef RO_PUF_MARGIN_EN
    logic [N_BITS-1:0] unstable;
`endif

    always #5 clk = ~clk;

    ro_puf_controller #(
        .N_BITS(N_BITS), .SEL_W(SEL_W), .CNT_W(CNT_W), .WINDOW(WINDOW),
        .CLR_CYCLES(CLR_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES), .MARGIN(MARGIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .challenge_a(challenge_a), .challenge_b(challenge_b),
        .busy(busy), .resp_valid(resp_valid), .response(response),
        .sel_a(sel_a), .sel_b(sel_b), .ro_en(ro_en), .cnt_clr(cnt_clr),
`ifdef RO_PUF_MARGIN_EN
        .unstable(unstable),
`endif
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    // Oscillator model: each RO adds freq[sel] counts per enabled cycle.
    int freq [16];
    always @(posedge clk) begin
        cnt_a <= cnt_clr ? '0 : ro_en ? cnt_a + CNT_W'(freq[sel_a]) : cnt_a;
        cnt_b <= cnt_clr ? '0 : ro_en ? cnt_b + CNT_W'(freq[sel_b]) : cnt_b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N_BITS-1:0] resp;
        logic [N_BITS-1:0] unst;
        int                acc;
    } exp_t;
    exp_t       sb_q [$];
    logic [7:0] sel_q [$];

    int total = 0, bad = 0;

    // Reference: bit i compares the whole-window counts of oscillators
    // (a+i) mod 16 and (b+i) mod 16.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.resp = '0; e.unst = '0; e.acc = 0;
        for (int i = 0; i < N_BITS; i++) begin
            int sa, sb, ca, cb, d;
            sa = (a + i) % 16; sb = (b + i) % 16;
            ca = WINDOW * freq[sa]; cb = WINDOW * freq[sb];
            d  = (ca > cb) ? ca - cb : cb - ca;
            e.resp[i] = (sa != sb) && (ca > cb);
            e.unst[i] = (sa == sb) || (d < MARGIN);
        end
        return e;
    endfunction

    task automatic run(input int a, input int b);
        exp_t e;
        e = model(a, b);
        @(negedge clk);
        challenge_a = SEL_W'(a); challenge_b = SEL_W'(b); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        challenge_a = SEL_W'($urandom); challenge_b = SEL_W'($urandom);
        e.acc = cyc;
        sb_q.push_back(e);
        for (int i = 0; i < N_BITS; i++)
            sel_q.push_back({4'((a + i) % 16), 4'((b + i) % 16)});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_freq();
        for (int i = 0; i < 16; i++) freq[i] = int'($urandom_range(1, 200));
    endtask

    // Monitor: every comparison happens here.
    initial begin
        bit ro_prev;
        int ro_len;
        exp_t e;
        logic [7:0] s;
        ro_prev = 0; ro_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                total++;
                if (ro_en || cnt_clr || busy || resp_valid || response != 0 ||
                    sel_a != 0 || sel_b != 0) begin
                    bad++;
                    $display("FAIL reset_outputs ro_en=%b cnt_clr=%b busy=%b rv=%b resp=%h sel=%h/%h need all 0",
                             ro_en, cnt_clr, busy, resp_valid, response, sel_a, sel_b);
                end
                ro_prev = 0; ro_len = 0;
            end else begin
                if (ro_en || cnt_clr) begin
                    total++;
                    if (ro_en && cnt_clr) begin
                        bad++; $display("FAIL en_clr_overlap got both high need exclusive");
                    end
                end
                if (ro_en && !ro_prev) begin
                    total++;
                    if (sel_q.size() == 0) begin
                        bad++; $display("FAIL ro_en_unexpected sel=%0d/%0d", sel_a, sel_b);
                    end else begin
                        s = sel_q.pop_front();
                        if ({sel_a, sel_b} != s) begin
                            bad++;
                            $display("FAIL sel got=%0d/%0d need=%0d/%0d", sel_a, sel_b, s[7:4], s[3:0]);
                        end
                    end
                end
                if (ro_en) ro_len++;
                else if (ro_prev) begin
                    total++;
                    if (ro_len != WINDOW) begin
                        bad++; $display("FAIL ro_en_width got=%0d need=%0d", ro_len, WINDOW);
                    end
                    ro_len = 0;
                end
                ro_prev = ro_en;

                if (resp_valid) begin
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++; $display("FAIL resp_valid_unexpected resp=%h", response);
                    end else begin
                        e = sb_q.pop_front();
                        if (response != e.resp) begin
                            bad++; $display("FAIL response got=%h need=%h", response, e.resp);
                        end
                        total++;
                        if (cyc - e.acc != LAT) begin
                            bad++; $display("FAIL latency got=%0d need=%0d", cyc - e.acc, LAT);
                        end
                        total++;
                        if (busy) begin
                            bad++; $display("FAIL busy_at_valid got=1 need=0");
                        end
`ifdef RO_PUF_MARGIN_EN
                        total++;
                        if (unstable != e.unst) begin
                            bad++; $display("FAIL unstable got=%h need=%h", unstable, e.unst);
                        end
`endif
                    end
                end else begin
                    total++;
                    if (busy != (sb_q.size() != 0)) begin
                        bad++; $display("FAIL busy got=%b need=%b", busy, sb_q.size() != 0);
                    end
                    if (sb_q.size() != 0 && cyc - sb_q[0].acc > LAT + 10) begin
                        total++; bad++;
                        $display("FAIL timeout no resp_valid within %0d cycles", LAT + 10);
                        sb_q.delete(); sel_q.delete();
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; challenge_a = '0; challenge_b = '0;
        for (int i = 0; i < 16; i++) freq[i] = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: counts 100 vs 90 on every pair -> all ones.
        for (int i = 0; i < 16; i++) freq[i] = (i < 8) ? 10 : 9;
        run(0, 8); wait_done();

        // Select wrap-around.
        rand_freq(); run(14, 2); wait_done();

        // Equal counts everywhere -> all zeros.
        for (int i = 0; i < 16; i++) freq[i] = 5;
        run(6, 11); wait_done();

        // Same oscillator on both sides -> forced zeros, same timing.
        rand_freq(); run(3, 3); wait_done();

        // start pulsed mid-run must be ignored.
        rand_freq(); run(1, 9);
        repeat (19) @(negedge clk);
        challenge_a = 4'd7; challenge_b = 4'd12; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done();

        // Reset mid-run aborts; a fresh start then completes.
        rand_freq(); run(5, 6);
        repeat (29) @(posedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete(); sel_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(2, 12); wait_done();

        // Randomized runs.
        for (int k = 0; k < 10; k++) begin
            rand_freq();
            if (k % 4 == 3) freq[$urandom_range(0, 15)] = freq[$urandom_range(0, 15)];
            run(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
